// File: rtl/mac_array_ctrl.sv
// Sequencer for one MxM signed matrix multiply on the elementwise MAC array.
// Latches A/B, clears the array, streams M operand steps, buffers the result.
module mac_array_ctrl #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int M      = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start_valid,
    output logic                                     start_ready,
    input  logic signed [M-1:0][M-1:0][DATA_W-1:0]   A_in,
    input  logic signed [M-1:0][M-1:0][DATA_W-1:0]   B_in,
    output logic                                     mac_en,
    output logic                                     mac_clear,
    output logic signed [M-1:0][M-1:0][DATA_W-1:0]   mac_a,
    output logic signed [M-1:0][M-1:0][DATA_W-1:0]   mac_b,
    input  logic signed [M-1:0][M-1:0][ACC_W-1:0]    mac_acc,
    output logic                                     res_valid,
    input  logic                                     res_ready,
    output logic signed [M-1:0][M-1:0][ACC_W-1:0]    res,
    output logic                                     busy
);

    localparam int KW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        SETTLE
    } state_t;

    state_t state, state_nx;
    logic [KW-1:0] k, k_nx;
    logic [M-1:0][M-1:0][DATA_W-1:0] a_reg, b_reg;
    logic accept;
    logic load_res;

    assign accept = start_valid && start_ready;
    assign busy   = (state != IDLE);

    always_comb begin
        state_nx    = state;
        k_nx        = k;
        start_ready = 1'b0;
        mac_en      = 1'b0;
        mac_clear   = 1'b0;
        mac_a       = '0;
        mac_b       = '0;
        load_res    = 1'b0;
        unique case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_nx = CLEAR;
            end
            CLEAR: begin
                mac_clear = 1'b1;
                k_nx      = '0;
                state_nx  = RUN;
            end
            RUN: begin
                mac_en = 1'b1;
                // Step k broadcasts column k of A and row k of B.
                for (int i = 0; i < M; i++) begin
                    for (int j = 0; j < M; j++) begin
                        mac_a[i][j] = a_reg[i][k];
                        mac_b[i][j] = b_reg[k][j];
                    end
                end
                k_nx = k + 1'b1;
                if (k == KW'(M - 1)) state_nx = SETTLE;
            end
            SETTLE: begin
                if (!res_valid || res_ready) begin
                    load_res = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            if (accept) begin
                a_reg <= A_in;
                b_reg <= B_in;
            end
        end
    end

    // A load from SETTLE wins over a same-edge consume, keeping valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res       <= '0;
            res_valid <= 1'b0;
        end else if (load_res) begin
            res       <= mac_acc;
            res_valid <= 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Bench for mac_array_ctrl: behavioural MAC array, result scoreboard,
// directed jobs plus a randomized back-to-back run.
module tb_mac_array_ctrl;

    typedef logic [3:0][3:0][7:0]  mat_t;
    typedef logic [3:0][3:0][31:0] res_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start_valid;
    logic start_ready;
    mat_t A_in, B_in;
    logic mac_en, mac_clear;
    mat_t mac_a, mac_b;
    res_t mac_acc;
    logic res_valid;
    logic res_ready;
    res_t res;
    logic busy;

    int   errors = 0;
    int   checks = 0;
    res_t sb[$];
    bit   rand_rdy = 1'b0;

    always #5 clk = ~clk;

    mac_array_ctrl #(.DATA_W(8), .ACC_W(32), .M(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .A_in(A_in), .B_in(B_in),
        .mac_en(mac_en), .mac_clear(mac_clear),
        .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
        .res_valid(res_valid), .res_ready(res_ready),
        .res(res), .busy(busy)
    );

    function automatic int mul(logic [7:0] x, logic [7:0] y);
        int sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        return sx * sy;
    endfunction

    // Elementwise MAC array.
    always @(posedge clk) begin
        if (mac_clear) mac_acc <= '0;
        else if (mac_en)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    mac_acc[i][j] <= mac_acc[i][j] + mul(mac_a[i][j], mac_b[i][j]);
    end

    function automatic res_t golden(mat_t a, mat_t b);
        res_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                int s;
                s = 0;
                for (int q = 0; q < 4; q++) s += mul(a[i][q], b[q][j]);
                r[i][j] = s;
            end
        return r;
    endfunction

    function automatic mat_t fill_mat(logic [7:0] v);
        mat_t m;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) m[i][j] = v;
        return m;
    endfunction

    function automatic res_t fill_res(logic [31:0] v);
        res_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) r[i][j] = v;
        return r;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) m[i][j] = 8'($urandom_range(0, 255));
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a handshake happens at the following posedge.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL res_extra: got %h expected none", res);
            end else begin
                res_t e;
                e = sb.pop_front();
                if (res !== e) begin
                    errors++;
                    $display("FAIL res_data: got %h expected %h", res, e);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            res_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic do_start(input mat_t a, input mat_t b, input res_t exp, input bit push);
        int n;
        @(negedge clk);
        start_valid = 1'b1;
        A_in = a;
        B_in = b;
        n = 0;
        while (!start_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            check("start_timeout", 32'(start_ready), 32'd1);
            start_valid = 1'b0;
        end else begin
            if (push) sb.push_back(exp);
            @(posedge clk);
            #1;
            start_valid = 1'b0;
        end
    endtask

    task automatic run_job(input mat_t a, input mat_t b, input res_t exp,
                           input bit push, input bit meddle,
                           output int rise, output int clr, output int en,
                           output int bad);
        rise = 0; clr = 0; en = 0; bad = 0;
        do_start(a, b, exp, push);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mac_clear) clr++;
            if (mac_en) en++;
            if (rise == 0 && res_valid) rise = c;
            if (c <= 6 && start_ready) bad++;
            if (meddle && c == 2) begin
                start_valid = 1'b1;
                A_in = fill_mat(8'd3);
                B_in = fill_mat(8'd5);
            end
            if (c == 6) start_valid = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mat_t a, b, ident;
        res_t e4, e5;
        int rise, clr, en, bad, n;

        rst_n = 1'b0;
        start_valid = 1'b0;
        res_ready = 1'b1;
        A_in = '0;
        B_in = '0;
        repeat (3) @(negedge clk);
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mac_en", 32'(mac_en), 32'd0);
        check("rst_res_zero", 32'(res == '0), 32'd1);
        rst_n = 1'b1;

        // Identity times counting matrix
        ident = '0;
        for (int i = 0; i < 4; i++) ident[i][i] = 8'd1;
        b = '0;
        e4 = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                b[i][j]  = 8'(4 * i + j + 1);
                e4[i][j] = 32'(4 * i + j + 1);
            end
        run_job(ident, b, e4, 1'b1, 1'b0, rise, clr, en, bad);
        check("id_latency", 32'(rise), 32'd7);
        check("id_clear_cycles", 32'(clr), 32'd1);
        check("id_en_cycles", 32'(en), 32'd4);
        check("id_start_ready_busy", 32'(bad), 32'd0);

        // Signed extremes, with a start request meddling during RUN
        run_job(fill_mat(8'h80), fill_mat(8'h80), fill_res(32'd65536),
                1'b1, 1'b1, rise, clr, en, bad);
        check("ext1_latency", 32'(rise), 32'd7);
        check("ext1_ignored_start", 32'(bad), 32'd0);
        run_job(fill_mat(8'h80), fill_mat(8'h7F), fill_res(-32'sd65024),
                1'b1, 1'b0, rise, clr, en, bad);
        check("ext2_latency", 32'(rise), 32'd7);

        // Back-pressure: job4 parked, job5 stalls in SETTLE
        @(posedge clk); #1; res_ready = 1'b0;
        e4 = fill_res(32'd14);
        run_job(ident, fill_mat(8'd14), e4, 1'b1, 1'b0, rise, clr, en, bad);
        check("bp_job4_valid", 32'(res_valid), 32'd1);
        e5 = fill_res(32'd4);
        do_start(fill_mat(8'd1), fill_mat(8'd1), e5, 1'b1);
        repeat (8) @(negedge clk);
        check("bp_stall_busy", 32'(busy), 32'd1);
        check("bp_stall_ready", 32'(start_ready), 32'd0);
        check("bp_hold_res", 32'(res == e4), 32'd1);
        @(posedge clk); #1; res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
        @(negedge clk);
        check("bp_valid_kept", 32'(res_valid), 32'd1);
        check("bp_idle", 32'(busy), 32'd0);
        check("bp_new_res", 32'(res == e5), 32'd1);
        @(posedge clk); #1; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1; res_ready = 1'b0;

        // Async reset at RUN k=2 with a parked result
        run_job(fill_mat(8'd2), fill_mat(8'd2), fill_res(32'd16), 1'b0, 1'b0,
                rise, clr, en, bad);
        do_start(rand_mat(), rand_mat(), '0, 1'b0);
        repeat (4) @(negedge clk);
        check("k2_mac_en", 32'(mac_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_res_valid", 32'(res_valid), 32'd0);
        check("arst_mac_en", 32'(mac_en), 32'd0);
        check("arst_start_ready", 32'(start_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1; res_ready = 1'b1;
        a = rand_mat();
        b = rand_mat();
        run_job(a, b, golden(a, b), 1'b1, 1'b0, rise, clr, en, bad);
        check("post_rst_latency", 32'(rise), 32'd7);

        // Back-to-back random jobs with random res_ready
        rand_rdy = 1'b1;
        for (int t = 0; t < 100; t++) begin
            a = rand_mat();
            b = rand_mat();
            do_start(a, b, golden(a, b), 1'b1);
        end
        @(posedge clk);
        rand_rdy = 1'b0;
        #2;
        res_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("final_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
